// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one instance per port.
// The requester (CPU load/store, debug/DMA) is the master; the arbiter is the slave.
interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Port A is the CPU load/store path, port B the debug/DMA path. Ties are
// broken round-robin on the last grant. Every transaction is IDLE -> ACCESS
// -> RESP, or IDLE -> RESP when a misaligned word access is rejected.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; arbitration and latching happen here
// ACCESS | one cycle with the memory enables driven for the winner
// RESP   | one cycle with the winner's ack (and err on a reject) high
module data_mem_arbiter #(
    parameter bit ALIGN_CHECK   = 1'b1,
    parameter int MEM_ADDR_BITS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   a,
    data_mem_arbiter_if.slave   b,
    output logic [31:0]         mem_access_addr,
    output logic [31:0]         mem_in,
    output logic                mem_write_en,
    output logic                mem_read_en,
    input  logic [31:0]         mem_out,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant_b;
    logic        win_b;
    logic        lat_we;

    logic        a_ack_q;
    logic        a_err_q;
    logic [31:0] a_rdata_q;
    logic        b_ack_q;
    logic        b_err_q;
    logic [31:0] b_rdata_q;

    logic        sel_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_reject;

    // Upper address bits are intentionally not forwarded to the memory.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^sel_addr[31:MEM_ADDR_BITS];

    // Arbitrate between the ports and mux the winner's request fields.
    always_comb begin
        sel_b      = b.req & (~a.req | ~last_grant_b);
        sel_we     = sel_b ? b.we    : a.we;
        sel_addr   = sel_b ? b.addr  : a.addr;
        sel_wdata  = sel_b ? b.wdata : a.wdata;
        sel_reject = ALIGN_CHECK && (sel_addr[1:0] != 2'b00);
    end

    // Transaction sequencer; all port and memory outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant_b    <= 1'b1;
            win_b           <= 1'b0;
            lat_we          <= 1'b0;
            a_ack_q         <= 1'b0;
            a_err_q         <= 1'b0;
            a_rdata_q       <= '0;
            b_ack_q         <= 1'b0;
            b_err_q         <= 1'b0;
            b_rdata_q       <= '0;
            mem_access_addr <= '0;
            mem_in          <= '0;
            mem_write_en    <= 1'b0;
            mem_read_en     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a.req || b.req) begin
                        win_b        <= sel_b;
                        last_grant_b <= sel_b;
                        lat_we       <= sel_we;
                        busy         <= 1'b1;
                        if (sel_reject) begin
                            state <= RESP;
                            if (sel_b) begin
                                b_ack_q   <= 1'b1;
                                b_err_q   <= 1'b1;
                                b_rdata_q <= '0;
                            end else begin
                                a_ack_q   <= 1'b1;
                                a_err_q   <= 1'b1;
                                a_rdata_q <= '0;
                            end
                        end else begin
                            state           <= ACCESS;
                            mem_access_addr <= 32'(sel_addr[MEM_ADDR_BITS-1:0]);
                            mem_in          <= sel_wdata;
                            mem_write_en    <= sel_we;
                            mem_read_en     <= ~sel_we;
                        end
                    end
                end
                ACCESS: begin
                    state           <= RESP;
                    mem_access_addr <= '0;
                    mem_in          <= '0;
                    mem_write_en    <= 1'b0;
                    mem_read_en     <= 1'b0;
                    if (win_b) begin
                        b_ack_q <= 1'b1;
                        b_err_q <= 1'b0;
                        if (!lat_we) b_rdata_q <= mem_out;
                    end else begin
                        a_ack_q <= 1'b1;
                        a_err_q <= 1'b0;
                        if (!lat_we) a_rdata_q <= mem_out;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    a_ack_q <= 1'b0;
                    a_err_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    b_err_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a.ack   = a_ack_q;
    assign a.err   = a_err_q;
    assign a.rdata = a_rdata_q;
    assign b.ack   = b_ack_q;
    assign b.err   = b_err_q;
    assign b.rdata = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a table of single-port transactions, hand
// sequences for ties, back-to-back requests, unaligned pass-through and
// reset mid-access, then random traffic against a transaction-level model.
module tb_data_mem_arbiter;

    logic clk;
    logic rst_n;

    // Aligned-check instance (default parameters) with its memory.
    data_mem_arbiter_if a1_if ();
    data_mem_arbiter_if b1_if ();
    logic [31:0] mem_access_addr1, mem_in1, mem_out1;
    logic        mem_write_en1, mem_read_en1, busy1;
    logic [31:0] mem1 [128] = '{default: 32'h0};

    // Pass-through instance (ALIGN_CHECK=0) with its memory.
    data_mem_arbiter_if a0_if ();
    data_mem_arbiter_if b0_if ();
    logic [31:0] mem_access_addr0, mem_in0, mem_out0;
    logic        mem_write_en0, mem_read_en0, busy0;
    logic [31:0] mem0 [128] = '{126: 32'hA5A5_5A5A, default: 32'h0};

    data_mem_arbiter dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1_if.slave), .b(b1_if.slave),
        .mem_access_addr(mem_access_addr1), .mem_in(mem_in1),
        .mem_write_en(mem_write_en1), .mem_read_en(mem_read_en1),
        .mem_out(mem_out1), .busy(busy1)
    );

    data_mem_arbiter #(.ALIGN_CHECK(1'b0), .MEM_ADDR_BITS(7)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a0_if.slave), .b(b0_if.slave),
        .mem_access_addr(mem_access_addr0), .mem_in(mem_in0),
        .mem_write_en(mem_write_en0), .mem_read_en(mem_read_en0),
        .mem_out(mem_out0), .busy(busy0)
    );

    always @(posedge clk) if (mem_write_en1) mem1[mem_access_addr1[6:0]] <= mem_in1;
    assign mem_out1 = mem1[mem_access_addr1[6:0]];
    always @(posedge clk) if (mem_write_en0) mem0[mem_access_addr0[6:0]] <= mem_in0;
    assign mem_out0 = mem0[mem_access_addr0[6:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: memory image, per-port rdata, last grant.
    logic [31:0] ref_mem [128];
    logic [31:0] ref_rd  [2];
    bit          ref_lg_b;

    typedef struct {
        bit          port_b;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_txn(input int p, input bit we, input logic [31:0] addr,
                                      input logic [31:0] wdata, output bit rej,
                                      output logic [31:0] rd);
        rej = (addr[1:0] != 2'b00);
        if (rej) rd = 32'h0;
        else if (we) begin
            ref_mem[addr[6:0]] = wdata;
            rd = ref_rd[p];
        end else rd = ref_mem[addr[6:0]];
        ref_rd[p] = rd;
        ref_lg_b  = (p == 1);
    endfunction

    function automatic void model_reset();
        ref_rd[0] = 32'h0;
        ref_rd[1] = 32'h0;
        ref_lg_b  = 1'b1;
    endfunction

    task automatic drive_port(input bit pb, input bit req, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (pb) begin
            b1_if.req = req; b1_if.we = we; b1_if.addr = addr; b1_if.wdata = wdata;
        end else begin
            a1_if.req = req; a1_if.we = we; a1_if.addr = addr; a1_if.wdata = wdata;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        bit done;
        bit rej;
        logic [31:0] rd;
        logic ack_w, ack_l, err_w;
        logic [31:0] rdata_w;
        @(negedge clk);
        drive_port(v.port_b, 1'b1, v.we, v.addr, v.wdata);
        done = 1'b0;
        for (int cyc = 1; cyc <= 6 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (v.exp_lat == 2) begin
                    chk("vec_mem_addr", mem_access_addr1, 32'(v.addr[6:0]));
                    chk("vec_mem_we", mem_write_en1, v.we);
                    chk("vec_mem_re", mem_read_en1, !v.we);
                    chk("vec_mem_in", mem_in1, v.wdata);
                end else begin
                    chk("vec_rej_enables", {mem_write_en1, mem_read_en1}, 32'h0);
                end
            end
            ack_w   = v.port_b ? b1_if.ack   : a1_if.ack;
            ack_l   = v.port_b ? a1_if.ack   : b1_if.ack;
            err_w   = v.port_b ? b1_if.err   : a1_if.err;
            rdata_w = v.port_b ? b1_if.rdata : a1_if.rdata;
            if (ack_w || ack_l) begin
                chk("vec_winner_ack", ack_w, 1'b1);
                chk("vec_loser_ack", ack_l, 1'b0);
                chk("vec_latency", cyc, v.exp_lat);
                chk("vec_err", err_w, v.exp_err);
                chk("vec_rdata", rdata_w, v.exp_rdata);
                drive_port(v.port_b, 1'b0, 1'b0, 32'h0, 32'h0);
                done = 1'b1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL vec_timeout: got no ack expected ack for addr %h", v.addr);
            drive_port(v.port_b, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        model_txn(v.port_b ? 1 : 0, v.we, v.addr, v.wdata, rej, rd);
        @(negedge clk);
        chk("vec_idle_busy", busy1, 1'b0);
    endtask

    task automatic run_txn(input bit ra, input bit wa, input logic [31:0] aa, input logic [31:0] da,
                           input bit rb, input bit wb, input logic [31:0] ab, input logic [31:0] db);
        bit pa, pb, p, rej;
        int cyc, exp_cyc;
        logic [31:0] exp_rd;
        @(negedge clk);
        drive_port(1'b0, ra, wa, aa, da);
        drive_port(1'b1, rb, wb, ab, db);
        pa = ra; pb = rb; cyc = 0;
        if (!(pa || pb)) return;
        p = (pa && pb) ? !ref_lg_b : !pa;
        if (p) model_txn(1, wb, ab, db, rej, exp_rd);
        else   model_txn(0, wa, aa, da, rej, exp_rd);
        exp_cyc = rej ? 1 : 2;
        while ((pa || pb) && cyc < 24) begin
            @(negedge clk);
            cyc++;
            if (a1_if.ack || b1_if.ack) begin
                chk("dual_ack", a1_if.ack & b1_if.ack, 1'b0);
                chk("winner", b1_if.ack, p);
                chk("ack_cycle", cyc, exp_cyc);
                if (p) begin
                    chk("b_err", b1_if.err, rej);
                    chk("b_rdata", b1_if.rdata, exp_rd);
                    chk("a_rdata_hold", a1_if.rdata, ref_rd[0]);
                    b1_if.req = 1'b0; pb = 1'b0;
                end else begin
                    chk("a_err", a1_if.err, rej);
                    chk("a_rdata", a1_if.rdata, exp_rd);
                    chk("b_rdata_hold", b1_if.rdata, ref_rd[1]);
                    a1_if.req = 1'b0; pa = 1'b0;
                end
                if (pa || pb) begin
                    p = pb;
                    if (p) model_txn(1, wb, ab, db, rej, exp_rd);
                    else   model_txn(0, wa, aa, da, rej, exp_rd);
                    exp_cyc = cyc + 1 + (rej ? 1 : 2);
                end
            end
        end
        if (pa || pb) begin
            total++; bad++;
            $display("FAIL txn_timeout: got pending a=%0d b=%0d expected none", pa, pb);
            a1_if.req = 1'b0; b1_if.req = 1'b0;
        end
        @(negedge clk);
        chk("txn_idle_busy", busy1, 1'b0);
    endtask

    task automatic run_random(input int n);
        int sel;
        logic [31:0] aa, ab;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 2);
            aa = $urandom; ab = $urandom;
            if ($urandom_range(0, 3) != 0) aa[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ab[1:0] = 2'b00;
            run_txn(sel != 1, 1'($urandom_range(0, 1)), aa, $urandom,
                    sel != 0, 1'($urandom_range(0, 1)), ab, $urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rej;
        logic [31:0] rd;
        bit exp_busy [6];
        bit exp_ack  [6];
        int k;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         2};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0,         1};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_007C, 32'hCAFE_F00D, 1'b0, 32'h0,         2};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h5555_0000, 1'b0, 32'hCAFE_F00D, 2};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h0000_1234, 1'b1, 32'h0,         1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_007C, 32'h0,         1'b0, 32'hCAFE_F00D, 2};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0090, 32'h1111_2222, 1'b0, 32'hCAFE_F00D, 2};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1111_2222, 2};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'hCAFE_F00D, 2};

        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        model_reset();

        rst_n = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        a0_if.req = 1'b0; a0_if.we = 1'b0; a0_if.addr = 32'h0; a0_if.wdata = 32'h0;
        b0_if.req = 1'b0; b0_if.we = 1'b0; b0_if.addr = 32'h0; b0_if.wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {a1_if.ack, b1_if.ack, a1_if.err, b1_if.err}, 32'h0);
        chk("rst_a_rdata", a1_if.rdata, 32'h0);
        chk("rst_b_rdata", b1_if.rdata, 32'h0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_mem_en", {mem_write_en1, mem_read_en1}, 32'h0);
        chk("rst_mem_addr", mem_access_addr1, 32'h0);
        chk("rst_mem_in", mem_in1, 32'h0);
        rst_n = 1'b1;

        // Simultaneous requests right after reset: A wins the first tie.
        run_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // A read held through its ack and one cycle beyond: re-granted.
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_ack  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        model_txn(0, 1'b0, 32'h40, 32'h0, rej, rd);
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("held_busy", busy1, exp_busy[k]);
            chk("held_ack", a1_if.ack, exp_ack[k]);
            if (exp_ack[k]) chk("held_rdata", a1_if.rdata, rd);
            if (k == 4) a1_if.req = 1'b0;
        end
        model_txn(0, 1'b0, 32'h40, 32'h0, rej, rd);

        // Unaligned read near the top passes through when the check is off.
        @(negedge clk);
        b0_if.req = 1'b1; b0_if.we = 1'b0; b0_if.addr = 32'h7E;
        @(negedge clk);
        chk("pass_mem_addr", mem_access_addr0, 32'h7E);
        chk("pass_mem_re", mem_read_en0, 1'b1);
        chk("pass_mem_we", mem_write_en0, 1'b0);
        @(negedge clk);
        chk("pass_ack", b0_if.ack, 1'b1);
        chk("pass_err", b0_if.err, 1'b0);
        chk("pass_rdata", b0_if.rdata, 32'hA5A5_5A5A);
        chk("pass_mem_re_off", mem_read_en0, 1'b0);
        b0_if.req = 1'b0;
        @(negedge clk);
        chk("pass_busy", busy0, 1'b0);

        run_random(40);

        // Reset asserted during the ACCESS cycle of a write aborts it.
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(posedge clk);
        #2;
        chk("abort_we_before", mem_write_en1, 1'b1);
        chk("abort_addr_before", mem_access_addr1, 32'h20);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async", mem_write_en1, 1'b0);
        chk("abort_no_ack", a1_if.ack, 1'b0);
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_word", mem1[7'h20], ref_mem[7'h20]);
        model_reset();
        rst_n = 1'b1;
        for (k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_ack_after", a1_if.ack, 1'b0);
            chk("abort_busy_after", busy1, 1'b0);
        end

        run_random(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL provide parameter ALIGN_CHECK, default 1, meaning: 1 rejects word accesses with addr[1:0]!=0, 0 passes them through.
REQ-002 SHALL provide parameter MEM_ADDR_BITS, default 7, meaning: number of low address bits forwarded to the memory, with upper bits driven 0.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_req  input  1  port A (CPU load/store) request, held until a_ack.
REQ-006 a_we  input  1  port A write (1) / read (0).
REQ-007 a_addr  input  32  port A byte address.
REQ-008 a_wdata  input  32  port A write data.
REQ-009 a_ack  output  1  port A one-cycle completion strobe.
REQ-010 a_err  output  1  port A misaligned-reject flag, valid with a_ack.
REQ-011 a_rdata  output  32  port A read data, valid with a_ack.
REQ-012 b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata SHALL match REQ-005..011 in direction and width for port B (debug/DMA).
REQ-013 mem_access_addr  output  32  memory address.
REQ-014 mem_in  output  32  memory write data.
REQ-015 mem_write_en  output  1  memory write enable (memory commits on rising edge).
REQ-016 mem_read_en  output  1  memory read enable.
REQ-017 mem_out  input  32  memory combinational read data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered or decoded from registered state only.
REQ-020 IDLE: at an edge with no request, SHALL remain IDLE; with a request, SHALL latch winner, we, addr, wdata and go to ACCESS (or RESP if rejected per REQ-024).
REQ-021 Arbitration: only one request -> that port wins; both -> port other than last_grant wins; last_grant updates on every grant, including rejects.
REQ-022 ACCESS (exactly one cycle): SHALL drive mem_access_addr = latched addr[MEM_ADDR_BITS-1:0] zero-extended, mem_write_en = we, mem_read_en = ~we, mem_in = wdata; at the closing edge SHALL capture mem_out into winner's rdata (reads only) and go to RESP.
REQ-023 RESP (exactly one cycle): SHALL assert winner's ack only; then return to IDLE; loser's outputs unchanged.
REQ-024 When ALIGN_CHECK=1 and latched addr[1:0]!=0: SHALL skip ACCESS, no memory enable, winner rdata=0, err=1 in RESP.
REQ-025 err SHALL be 0 on every non-rejected ack; rdata SHALL hold its last value between acks; rdata unchanged after writes.
REQ-026 Outside ACCESS: mem_write_en=0, mem_read_en=0, mem_access_addr=0, mem_in=0.
REQ-027 Latency: req sampled at edge N -> memory enables during cycle N..N+1 -> ack high N+1..N+2 -> IDLE at N+2; reject: ack high N..N+1.
REQ-028 Requester SHALL drop req by the edge ending ack; req still high when IDLE next samples is a new request.
REQ-029 Inputs changing while not in IDLE SHALL be ignored.
REQ-030 Addresses near the top of the memory SHALL be forwarded unmodified; wrap is the memory's behaviour.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, last_grant=B (so A wins first tie), acks/errs/busy/mem enables/mem_access_addr/mem_in=0, a_rdata=b_rdata=0.
REQ-032 Reset during ACCESS SHALL drop mem_write_en before the next edge (write aborted); no ack for the aborted transaction.
REQ-033 First grant possible at first rising edge after rst_n rises.

Verification
REQ-034 A write 0x0000_0010 <- 0xDEADBEEF, then A read 0x10 -> second ack a_rdata=0xDEADBEEF, a_err=0; ack 2 cycles after each req sample.
REQ-035 a_req and b_req rise together after reset, both held and re-requested -> grants A,B,A,B; never two acks same cycle.
REQ-036 B read addr 0x13 with ALIGN_CHECK=1 -> b_ack next cycle, b_err=1, b_rdata=0, mem_read_en never high.
REQ-037 B read 0x7E with ALIGN_CHECK=0 -> mem_access_addr=0x7E, mem_read_en high one cycle, b_rdata=mem_out captured.
REQ-038 rst_n low mid-ACCESS of A write 0x20 <- 0x12345678 -> mem_write_en falls asynchronously, word at 0x20 unchanged, no a_ack.
REQ-039 a_req held through ack and one cycle beyond -> second transaction granted and acked, busy low only for one IDLE cycle between.
